// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - Morse symbol encoding, player states and unit lengths
package morse_pkg;

    typedef enum logic [1:0] {
        SYM_DOT        = 2'b00,
        SYM_DASH       = 2'b01,
        SYM_LETTER_GAP = 2'b10,
        SYM_WORD_GAP   = 2'b11
    } symbol_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_MARK  = 3'd3,
        ST_SPACE = 3'd4
    } state_e;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd2;
    localparam logic [2:0] WORD_GAP_UNITS   = 3'd6;
    localparam logic [2:0] ELEMENT_GAP_UNITS = 3'd1;

    function automatic logic [2:0] sym_units(symbol_e s);
        case (s)
            SYM_DOT:        return DOT_UNITS;
            SYM_DASH:       return DASH_UNITS;
            SYM_LETTER_GAP: return LETTER_GAP_UNITS;
            default:        return WORD_GAP_UNITS;
        endcase
    endfunction

    function automatic logic sym_is_mark(symbol_e s);
        return (s == SYM_DOT) || (s == SYM_DASH);
    endfunction

endpackage

// File: rtl/unit_timer.sv
// rtl/unit_timer.sv - cycle prescaler plus unit down-counter, expires on last unit tick
module unit_timer #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] units,
    output logic       expired
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    units_q, units_d;
    logic          tick;

    assign tick    = (cyc_q == LAST);
    assign expired = tick && (units_q == 3'd1);

    // Prescaler idles once the unit count is exhausted.
    always_comb begin
        cyc_d   = cyc_q;
        units_d = units_q;
        if (load) begin
            cyc_d   = '0;
            units_d = units;
        end else if (units_q != 3'd0) begin
            if (tick) begin
                cyc_d   = '0;
                units_d = units_q - 3'd1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            units_q <= 3'd0;
        end else begin
            cyc_q   <= cyc_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/morse_player.sv
// rtl/morse_player.sv - drains the Morse symbol FIFO and keys the tone output
module morse_player
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       fifo_empty,
    input  logic [1:0] fifo_data,
    output logic       fifo_re,
    output logic       tone_on,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    logic       done_q, done_d;
    logic       tmr_load;
    logic [2:0] tmr_units;
    logic       tmr_expired;
    symbol_e    sym;

    assign sym = symbol_e'(fifo_data);

    unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .units  (tmr_units),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_units = 3'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tmr_load  = 1'b1;
                tmr_units = sym_units(sym);
                state_d   = sym_is_mark(sym) ? ST_MARK : ST_SPACE;
            end
            ST_MARK: begin
                if (tmr_expired) begin
                    tmr_load  = 1'b1;
                    tmr_units = ELEMENT_GAP_UNITS;
                    state_d   = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (tmr_expired) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything, including start in IDLE.
        if (abort) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign fifo_re = (state_q == ST_FETCH) && !fifo_empty;
    assign tone_on = (state_q == ST_MARK);
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

endmodule
